easy_axi_txn_sched: RTL and testbench

- Transaction scheduler that shares one EASY_AXI master between NUM_REQ requesters.
- Arbitrates round-robin among requesters and drives the master's txn_start/txn_type handshake, holding txn_start for START_HOLD cycles.
- Waits for txn_done and returns a per-requester completion pulse.
- Sits directly above the EASY_AXI master and adds illegal-type rejection and a done-timeout watchdog.

---
 rtl/easy_axi_pkg.sv | 22 ++
 rtl/easy_axi_rr_arb.sv | 42 ++++
 rtl/easy_axi_txn_sched.sv | 165 ++++++++++++++++
 tb/tb_easy_axi_txn_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/easy_axi_pkg.sv
// Shared EASY_AXI transaction type codes and scheduler state encoding.
// Pure declarations: no latency, no backpressure.
package easy_axi_pkg;

    localparam logic [1:0] TXN_NONE = 2'b00;
    localparam logic [1:0] TXN_WR   = 2'b01;
    localparam logic [1:0] TXN_RD   = 2'b10;
    localparam logic [1:0] TXN_RSV  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

    function automatic logic txn_type_legal(input logic [1:0] t);
        return (t == TXN_WR) || (t == TXN_RD);
    endfunction

endpackage

// File: rtl/easy_axi_rr_arb.sv
// Combinational round-robin arbiter: rotate by pointer, pick lowest, rotate back.
// Zero latency; requests are sampled level-wise, no backpressure of its own.
module easy_axi_rr_arb #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);
    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] rot_idx;
    logic [IW:0]   sum;

    always_comb begin
        // Bit 0 of rot is the requester sitting at the pointer.
        rot     = N'({req, req} >> ptr);
        rot_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && rot[i]) begin
                rot_idx = IW'(i);
                any     = 1'b1;
            end
        end
        sum = {1'b0, rot_idx} + {1'b0, ptr};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[IW-1:0];
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/easy_axi_txn_sched.sv
// Shares one EASY_AXI master among NUM_REQ requesters; 1-cycle ARB, START_HOLD-cycle start.
// Requests wait (level) until granted; completion returned as a one-cycle pulse.
module easy_axi_txn_sched
    import easy_axi_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int START_HOLD = 5,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_type,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   cpl_valid,
    output logic                 cpl_err,
    output logic                 busy,
    output logic                 txn_start,
    output logic [1:0]           txn_type,
    input  logic                 txn_done
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int IW   = $clog2(NUM_REQ);

    localparam logic [TO_W-1:0] HOLD_LAST = TO_W'(START_HOLD - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    sched_state_e    state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      type_q, type_d;
    logic            err_q, err_d;
    logic            done_seen_q, done_seen_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            done_q, done_d;

    logic               done_rise;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [1:0]         win_type;

    easy_axi_rr_arb #(
        .N (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign done_d    = txn_done;
    assign done_rise = txn_done & ~done_q;
    assign txn_type  = type_q;

    always_comb begin
        win_type = TXN_NONE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                win_type = req_type[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        type_d      = type_q;
        err_d       = err_q;
        done_seen_d = done_seen_q;
        to_cnt_d    = '0;
        req_ready   = '0;
        cpl_valid   = '0;
        cpl_err     = 1'b0;
        txn_start   = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (arb_any) begin
                    req_ready   = arb_gnt;
                    idx_d       = arb_idx;
                    done_seen_d = 1'b0;
                    rr_ptr_d    = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    if (txn_type_legal(win_type)) begin
                        type_d  = win_type;
                        err_d   = 1'b0;
                        state_d = START;
                    end else begin
                        // Illegal type never reaches the master.
                        type_d  = TXN_NONE;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                txn_start = 1'b1;
                to_cnt_d  = to_cnt_q + TO_W'(1);
                if (done_rise) begin
                    done_seen_d = 1'b1;
                end
                if (to_cnt_q == HOLD_LAST) begin
                    err_d   = 1'b0;
                    state_d = (done_seen_q || done_rise) ? DONE : WAIT;
                end
            end
            WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // A done edge coinciding with expiry still counts as success.
                if (done_rise) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    cpl_valid[i] = (idx_q == IW'(i));
                end
                cpl_err = err_q;
                type_d  = TXN_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            type_q      <= TXN_NONE;
            err_q       <= 1'b0;
            done_seen_q <= 1'b0;
            to_cnt_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            type_q      <= type_d;
            err_q       <= err_d;
            done_seen_q <= done_seen_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_easy_axi_txn_sched.sv
// Directed bench for easy_axi_txn_sched with NUM_REQ=2, START_HOLD=5, TIMEOUT=64.
module tb_easy_axi_txn_sched;

    localparam int NUM_REQ    = 2;
    localparam int START_HOLD = 5;
    localparam int TIMEOUT    = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] req_type;
    logic [1:0] req_ready;
    logic [1:0] cpl_valid;
    logic       cpl_err;
    logic       busy;
    logic       txn_start;
    logic [1:0] txn_type;
    logic       txn_done;

    int n_cmp = 0;
    int n_bad = 0;

    easy_axi_txn_sched #(
        .NUM_REQ    (NUM_REQ),
        .START_HOLD (START_HOLD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_type  (req_type),
        .req_ready (req_ready),
        .cpl_valid (cpl_valid),
        .cpl_err   (cpl_err),
        .busy      (busy),
        .txn_start (txn_start),
        .txn_type  (txn_type),
        .txn_done  (txn_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_ready(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step();
            smp();
            if (req_ready != 2'b00) begin
                g = req_ready;
                break;
            end
        end
    endtask

    task automatic service(output logic [1:0] g, output logic [1:0] t,
                           output logic [1:0] c, output logic e);
        wait_ready(g);
        step();
        smp();
        t = txn_type;
        repeat (START_HOLD) step();
        txn_done = 1'b1;
        step();
        txn_done = 1'b0;
        smp();
        c = cpl_valid;
        e = cpl_err;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [1:0] g, t, c;
        logic       e;
        int         hi, early, starts, pulses;
        logic [1:0] exp_g [4];
        logic [1:0] exp_t [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_t = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_type  = 4'b0000;
        txn_done  = 1'b0;
        #1 rst_n  = 1'b0;
        repeat (2) step();
        smp();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(txn_start), 0);
        chk("rst_type", 32'(txn_type), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_cpl", 32'(cpl_valid), 0);
        step();
        rst_n = 1'b1;
        step();
        smp();
        chk("idle_busy", 32'(busy), 0);

        // Single write, done 20 cycles after start rise.
        step();
        req_valid = 2'b01;
        req_type  = 4'b0001;
        smp();
        chk("wr_idle_ready", 32'(req_ready), 0);
        step();
        smp();
        chk("wr_ready", 32'(req_ready), 1);
        step();
        req_valid = 2'b00;
        smp();
        chk("wr_type", 32'(txn_type), 1);
        hi = int'(txn_start);
        for (int k = 1; k < 7; k++) begin
            step();
            smp();
            hi += int'(txn_start);
        end
        chk("wr_start_len", 32'(hi), 5);
        chk("wr_wait_busy", 32'(busy), 1);
        early = 0;
        for (int k = 7; k < 20; k++) begin
            step();
            smp();
            if (cpl_valid != 2'b00) early++;
        end
        step();
        txn_done = 1'b1;
        smp();
        chk("wr_no_early_cpl", 32'(early), 0);
        chk("wr_type_stable", 32'(txn_type), 1);
        step();
        txn_done = 1'b0;
        smp();
        chk("wr_cpl", 32'(cpl_valid), 1);
        chk("wr_cpl_err", 32'(cpl_err), 0);
        step();
        smp();
        chk("wr_idle_after", 32'(busy), 0);

        // Illegal type on requester 1.
        step();
        req_valid = 2'b10;
        req_type  = 4'b1100;
        smp();
        starts = int'(txn_start);
        step();
        smp();
        chk("ill_ready", 32'(req_ready), 2);
        starts += int'(txn_start);
        step();
        req_valid = 2'b00;
        smp();
        chk("ill_cpl", 32'(cpl_valid), 2);
        chk("ill_err", 32'(cpl_err), 1);
        starts += int'(txn_start);
        step();
        smp();
        chk("ill_busy", 32'(busy), 0);
        chk("ill_no_start", 32'(starts), 0);

        // Round robin with both requesters held valid.
        step();
        req_valid = 2'b11;
        req_type  = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            service(g, t, c, e);
            chk($sformatf("rr_gnt%0d", i), 32'(g), 32'(exp_g[i]));
            chk($sformatf("rr_type%0d", i), 32'(t), 32'(exp_t[i]));
            chk($sformatf("rr_cpl%0d", i), 32'(c), 32'(exp_g[i]));
            chk($sformatf("rr_err%0d", i), 32'(e), 0);
        end
        step();
        req_valid = 2'b00;
        step();
        smp();
        chk("rr_idle", 32'(busy), 0);

        // Timeout: master never answers.
        step();
        req_valid = 2'b01;
        req_type  = 4'b0001;
        wait_ready(g);
        chk("to_gnt", 32'(g), 1);
        step();
        req_valid = 2'b00;
        smp();
        chk("to_rise", 32'(txn_start), 1);
        early = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            smp();
            if (cpl_valid != 2'b00) early++;
        end
        chk("to_no_early", 32'(early), 0);
        step();
        smp();
        chk("to_cpl", 32'(cpl_valid), 1);
        chk("to_err", 32'(cpl_err), 1);
        step();
        smp();
        chk("to_busy_drop", 32'(busy), 0);

        // Early done on the second START cycle.
        step();
        req_valid = 2'b10;
        req_type  = 4'b1000;
        wait_ready(g);
        chk("ed_gnt", 32'(g), 2);
        step();
        req_valid = 2'b00;
        smp();
        chk("ed_type", 32'(txn_type), 2);
        hi = int'(txn_start);
        step();
        txn_done = 1'b1;
        smp();
        hi += int'(txn_start);
        step();
        txn_done = 1'b0;
        smp();
        hi += int'(txn_start);
        for (int k = 3; k < 5; k++) begin
            step();
            smp();
            hi += int'(txn_start);
        end
        step();
        smp();
        hi += int'(txn_start);
        chk("ed_hold", 32'(hi), 5);
        chk("ed_cpl", 32'(cpl_valid), 2);
        chk("ed_err", 32'(cpl_err), 0);
        step();
        smp();
        chk("ed_idle", 32'(busy), 0);

        // Reset in the middle of WAIT.
        step();
        req_valid = 2'b01;
        req_type  = 4'b0001;
        wait_ready(g);
        step();
        req_valid = 2'b00;
        repeat (7) step();
        smp();
        chk("rs_pre_busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_start_drop", 32'(txn_start), 0);
        chk("rs_busy_drop", 32'(busy), 0);
        pulses = 0;
        repeat (3) begin
            step();
            smp();
            if (cpl_valid != 2'b00) pulses++;
        end
        step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            smp();
            if (cpl_valid != 2'b00) pulses++;
        end
        chk("rs_no_cpl", 32'(pulses), 0);
        step();
        req_valid = 2'b11;
        req_type  = 4'b1001;
        wait_ready(g);
        chk("rs_gnt_after", 32'(g), 1);
        step();
        req_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
